// File: rtl/ls_ctrl.sv
// rtl/ls_ctrl.sv - load/store execution unit: byte-serial memory transfers and LS CDB broadcast
//
// Holds one memory op at a time. It computes EA = vj + imm and moves 1/2/4 bytes,
// little-endian, through the memory arbiter. It then broadcasts the result on the
// LS CDB for one cycle.
//
// Optional feature: define LSC_PERF_CNT_EN to add the ld/st/io completed-op counters.
//
// Ports:
//   clk_in, rst_n_in          clock, synchronous active-low reset
//   rdy_in                    global enable; all state holds when low
//   rdy_lsb_in .. rob_id_lsb_in  op issue from the LS buffer
//   idle_lsb_out              high while no op is held
//   mem_req_out/mem_wr_out/mem_a_out/mem_dout_out  byte request to the arbiter
//   mem_gnt_in, mem_din_in    grant; read byte arrives the cycle after its grant
//   rdy_cdb_out/result_cdb_out/rob_id_cdb_out      LS CDB broadcast
//   refresh_rob_cdb_in        pipeline flush
//   ld_cnt_out/st_cnt_out/io_cnt_out   completed-op counters (LSC_PERF_CNT_EN only)

`ifndef OP_WIDTH
`define OP_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef LB
`define LB  4'd0
`define LH  4'd1
`define LW  4'd2
`define LBU 4'd3
`define LHU 4'd4
`define SB  4'd5
`define SH  4'd6
`define SW  4'd7
`endif

module ls_ctrl #(
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   rdy_lsb_in,
    input  logic [`OP_WIDTH-1:0]   opcode_lsb_in,
    input  logic [`DATA_WIDTH-1:0] vj_lsb_in,
    input  logic [`DATA_WIDTH-1:0] vk_lsb_in,
    input  logic [`DATA_WIDTH-1:0] imm_lsb_in,
    input  logic [`ROB_WIDTH-1:0]  rob_id_lsb_in,
    output logic                   idle_lsb_out,
    output logic                   mem_req_out,
    output logic                   mem_wr_out,
    output logic [ADDR_W-1:0]      mem_a_out,
    output logic [7:0]             mem_dout_out,
    input  logic                   mem_gnt_in,
    input  logic [7:0]             mem_din_in,
    output logic                   rdy_cdb_out,
    output logic [`DATA_WIDTH-1:0] result_cdb_out,
    output logic [`ROB_WIDTH-1:0]  rob_id_cdb_out,
    input  logic                   refresh_rob_cdb_in
`ifdef LSC_PERF_CNT_EN
    ,
    output logic [31:0]            ld_cnt_out,
    output logic [31:0]            st_cnt_out,
    output logic [31:0]            io_cnt_out
`endif
);

    // S_LAST is a one-cycle tail after the final grant: loads capture their last
    // read byte there, stores use it as the write-settle slot before broadcasting.
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_LAST, S_DONE} state_t;

    state_t                 state;
    logic [`OP_WIDTH-1:0]   op;
    logic [ADDR_W-1:0]      ea;
    logic [31:0]            st_data;
    logic [31:0]            ld_data;
    logic [`ROB_WIDTH-1:0]  tag;
    logic [2:0]             len;
    logic [2:0]             k;
    logic                   is_store;
    logic                   flushed;
    logic                   cap_pend;
    logic [1:0]             cap_idx;

    logic [2:0]             k_nx;
    logic [7:0]             st_byte;
    logic [ADDR_W-1:0]      ea_in;
    logic [31:0]            ld_full;
    logic [31:0]            ld_ext;
    logic                   load_abort;

    function automatic logic [2:0] op_len(input logic [`OP_WIDTH-1:0] o);
        case (o)
            `LB, `LBU, `SB: op_len = 3'd1;
            `LH, `LHU, `SH: op_len = 3'd2;
            default:        op_len = 3'd4;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [`OP_WIDTH-1:0] o);
        op_is_store = (o == `SB) || (o == `SH) || (o == `SW);
    endfunction

    assign idle_lsb_out = (state == S_IDLE);
    assign k_nx         = k + 3'd1;
    assign st_byte      = st_data[{k_nx[1:0], 3'b000} +: 8];
    assign ea_in        = ADDR_W'(vj_lsb_in + imm_lsb_in);
    assign load_abort   = refresh_rob_cdb_in && !is_store;

    // Load value including a byte still arriving this cycle, so S_LAST can
    // publish the complete word on the same edge that captures the last byte.
    always_comb begin
        ld_full = ld_data;
        if (cap_pend) begin
            ld_full[{cap_idx, 3'b000} +: 8] = mem_din_in;
        end
    end

    always_comb begin
        ld_ext = 32'd0;
        case (op)
            `LB:     ld_ext = {{24{ld_full[7]}}, ld_full[7:0]};
            `LH:     ld_ext = {{16{ld_full[15]}}, ld_full[15:0]};
            `LBU:    ld_ext = {24'd0, ld_full[7:0]};
            `LHU:    ld_ext = {16'd0, ld_full[15:0]};
            `LW:     ld_ext = ld_full;
            default: ld_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state          <= S_IDLE;
            op             <= '0;
            ea             <= '0;
            st_data        <= '0;
            ld_data        <= '0;
            tag            <= '0;
            len            <= '0;
            k              <= '0;
            is_store       <= 1'b0;
            flushed        <= 1'b0;
            cap_pend       <= 1'b0;
            cap_idx        <= '0;
            mem_req_out    <= 1'b0;
            mem_wr_out     <= 1'b0;
            mem_a_out      <= '0;
            mem_dout_out   <= '0;
            rdy_cdb_out    <= 1'b0;
            result_cdb_out <= '0;
            rob_id_cdb_out <= '0;
`ifdef LSC_PERF_CNT_EN
            ld_cnt_out     <= '0;
            st_cnt_out     <= '0;
            io_cnt_out     <= '0;
`endif
        end else if (rdy_in) begin
            cap_pend <= 1'b0;
            if (cap_pend) begin
                ld_data[{cap_idx, 3'b000} +: 8] <= mem_din_in;
            end
            case (state)
                S_IDLE: begin
                    if (rdy_lsb_in && !refresh_rob_cdb_in) begin
                        op           <= opcode_lsb_in;
                        ea           <= ea_in;
                        st_data      <= vk_lsb_in;
                        tag          <= rob_id_lsb_in;
                        len          <= op_len(opcode_lsb_in);
                        is_store     <= op_is_store(opcode_lsb_in);
                        k            <= 3'd0;
                        flushed      <= 1'b0;
                        ld_data      <= '0;
                        mem_req_out  <= 1'b1;
                        mem_wr_out   <= op_is_store(opcode_lsb_in);
                        mem_a_out    <= ea_in;
                        mem_dout_out <= vk_lsb_in[7:0];
                        state        <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (load_abort) begin
                        mem_req_out <= 1'b0;
                        mem_wr_out  <= 1'b0;
                        cap_pend    <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        // A flushed store is already committed: finish it quietly.
                        if (refresh_rob_cdb_in) begin
                            flushed <= 1'b1;
                        end
                        if (mem_gnt_in) begin
                            k <= k_nx;
                            if (!is_store) begin
                                cap_pend <= 1'b1;
                                cap_idx  <= k[1:0];
                            end
                            if (k_nx == len) begin
                                mem_req_out <= 1'b0;
                                mem_wr_out  <= 1'b0;
                                state       <= S_LAST;
                            end else begin
                                mem_a_out    <= ea + ADDR_W'(k_nx);
                                mem_dout_out <= st_byte;
                            end
                        end
                    end
                end
                S_LAST: begin
                    if (load_abort) begin
                        state <= S_IDLE;
                    end else begin
                        rdy_cdb_out    <= !(flushed || refresh_rob_cdb_in);
                        result_cdb_out <= ld_ext;
                        rob_id_cdb_out <= tag;
                        state          <= S_DONE;
`ifdef LSC_PERF_CNT_EN
                        if (is_store) begin
                            st_cnt_out <= st_cnt_out + 32'd1;
                        end else begin
                            ld_cnt_out <= ld_cnt_out + 32'd1;
                        end
                        if (ea >= ADDR_W'(IO_BASE)) begin
                            io_cnt_out <= io_cnt_out + 32'd1;
                        end
`endif
                    end
                end
                default: begin
                    rdy_cdb_out <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ls_ctrl.sv
// tb/tb_ls_ctrl.sv - directed self-checking bench for ls_ctrl

`ifndef OP_WIDTH
`define OP_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef LB
`define LB  4'd0
`define LH  4'd1
`define LW  4'd2
`define LBU 4'd3
`define LHU 4'd4
`define SB  4'd5
`define SH  4'd6
`define SW  4'd7
`endif

module tb_ls_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        rdy_lsb_in;
    logic [3:0]  opcode_lsb_in;
    logic [31:0] vj_lsb_in;
    logic [31:0] vk_lsb_in;
    logic [31:0] imm_lsb_in;
    logic [3:0]  rob_id_lsb_in;
    logic        idle_lsb_out;
    logic        mem_req_out;
    logic        mem_wr_out;
    logic [31:0] mem_a_out;
    logic [7:0]  mem_dout_out;
    logic        mem_gnt_in;
    logic [7:0]  mem_din_in;
    logic        rdy_cdb_out;
    logic [31:0] result_cdb_out;
    logic [3:0]  rob_id_cdb_out;
    logic        refresh_rob_cdb_in;
`ifdef LSC_PERF_CNT_EN
    logic [31:0] ld_cnt_out;
    logic [31:0] st_cnt_out;
    logic [31:0] io_cnt_out;
`endif

    ls_ctrl dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .rdy_in             (rdy_in),
        .rdy_lsb_in         (rdy_lsb_in),
        .opcode_lsb_in      (opcode_lsb_in),
        .vj_lsb_in          (vj_lsb_in),
        .vk_lsb_in          (vk_lsb_in),
        .imm_lsb_in         (imm_lsb_in),
        .rob_id_lsb_in      (rob_id_lsb_in),
        .idle_lsb_out       (idle_lsb_out),
        .mem_req_out        (mem_req_out),
        .mem_wr_out         (mem_wr_out),
        .mem_a_out          (mem_a_out),
        .mem_dout_out       (mem_dout_out),
        .mem_gnt_in         (mem_gnt_in),
        .mem_din_in         (mem_din_in),
        .rdy_cdb_out        (rdy_cdb_out),
        .result_cdb_out     (result_cdb_out),
        .rob_id_cdb_out     (rob_id_cdb_out),
        .refresh_rob_cdb_in (refresh_rob_cdb_in)
`ifdef LSC_PERF_CNT_EN
        ,
        .ld_cnt_out         (ld_cnt_out),
        .st_cnt_out         (st_cnt_out),
        .io_cnt_out         (io_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          t_issue = 0;
    int          hold_bad = 0;
    int          hold_cnt = 0;
    bit          hold_pend = 1'b0;
    logic [31:0] h_addr;
    logic [7:0]  h_dat;
    bit          gnt_alt = 1'b0;
    bit          gnt_phase = 1'b0;
    logic [7:0]  mem [0:1023];
    logic [31:0] g_addr[$];
    logic [31:0] g_wr[$];
    logic [31:0] g_dat[$];
    logic [31:0] cdb_res[$];
    logic [31:0] cdb_rob[$];
    logic [31:0] cdb_cyc[$];

    function automatic logic [31:0] qa(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: acts as the arbiter/memory for the current cycle, logs grants
    // and CDB broadcasts, then advances to #1 after the next rising edge.
    task automatic tick();
        logic [7:0] nd;
        logic       g;
        nd = mem_din_in;
        g  = mem_req_out && (!gnt_alt || gnt_phase);
        mem_gnt_in = g;
        if (rdy_cdb_out) begin
            cdb_res.push_back(result_cdb_out);
            cdb_rob.push_back(32'(rob_id_cdb_out));
            cdb_cyc.push_back(32'(cyc));
        end
        if (hold_pend && (!mem_req_out || mem_a_out !== h_addr || mem_dout_out !== h_dat)) begin
            hold_bad++;
        end
        hold_pend = mem_req_out && !g;
        if (hold_pend) hold_cnt++;
        h_addr = mem_a_out;
        h_dat  = mem_dout_out;
        if (g) begin
            g_addr.push_back(mem_a_out);
            g_wr.push_back(32'(mem_wr_out));
            g_dat.push_back(32'(mem_dout_out));
            if (mem_wr_out) mem[mem_a_out[9:0]] = mem_dout_out;
            else            nd = mem[mem_a_out[9:0]];
        end
        @(posedge clk_in);
        #1;
        mem_din_in = nd;
        cyc++;
        gnt_phase = ~gnt_phase;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [3:0] rob);
        opcode_lsb_in = op;
        vj_lsb_in     = vj;
        vk_lsb_in     = vk;
        imm_lsb_in    = imm;
        rob_id_lsb_in = rob;
        rdy_lsb_in    = 1'b1;
        t_issue       = cyc;
        tick();
        rdy_lsb_in    = 1'b0;
    endtask

    task automatic clear_logs();
        g_addr.delete();
        g_wr.delete();
        g_dat.delete();
        cdb_res.delete();
        cdb_rob.delete();
        cdb_cyc.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_idle"},   32'(idle_lsb_out), 32'd1);
        chk({tag, "_req"},    32'(mem_req_out), 32'd0);
        chk({tag, "_wr"},     32'(mem_wr_out), 32'd0);
        chk({tag, "_a"},      mem_a_out, 32'd0);
        chk({tag, "_dout"},   32'(mem_dout_out), 32'd0);
        chk({tag, "_cdb"},    32'(rdy_cdb_out), 32'd0);
        chk({tag, "_result"}, result_cdb_out, 32'd0);
        chk({tag, "_rob"},    32'(rob_id_cdb_out), 32'd0);
    endtask

    initial begin
        int t0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst_n_in = 1'b0; rdy_in = 1'b1; rdy_lsb_in = 1'b0; refresh_rob_cdb_in = 1'b0;
        opcode_lsb_in = '0; vj_lsb_in = '0; vk_lsb_in = '0; imm_lsb_in = '0; rob_id_lsb_in = '0;
        mem_gnt_in = 1'b0; mem_din_in = 8'h00;
        #1;
        tick(); tick();
        rst_n_in = 1'b1;
        tick();
        chk_reset_outputs("reset");
`ifdef LSC_PERF_CNT_EN
        chk("reset_ld_cnt", ld_cnt_out, 32'd0);
        chk("reset_io_cnt", io_cnt_out, 32'd0);
`endif

        // Word load, continuous grant.
        mem[10'h104] = 8'h78; mem[10'h105] = 8'h56; mem[10'h106] = 8'h34; mem[10'h107] = 8'h12;
        clear_logs();
        issue(`LW, 32'h100, 32'h0, 32'd4, 4'd1);
        repeat (8) tick();
        chk("lw_cdb_count", 32'(cdb_res.size()), 32'd1);
        chk("lw_result", qa(cdb_res, 0), 32'h1234_5678);
        chk("lw_rob", qa(cdb_rob, 0), 32'd1);
        chk("lw_latency", qa(cdb_cyc, 0), 32'(t_issue + 6));
        chk("lw_grants", 32'(g_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("lw_addr", qa(g_addr, i), 32'h104 + 32'(i));
        chk("lw_is_read", qa(g_wr, 0), 32'd0);

        // Sign/zero extension.
        mem[10'h010] = 8'h80; mem[10'h020] = 8'h00; mem[10'h021] = 8'h80;
        clear_logs();
        issue(`LB,  32'h10, 32'h0, 32'h0, 4'd2); repeat (6) tick();
        issue(`LBU, 32'h10, 32'h0, 32'h0, 4'd3); repeat (6) tick();
        issue(`LH,  32'h20, 32'h0, 32'h0, 4'd4); repeat (6) tick();
        issue(`LHU, 32'h20, 32'h0, 32'h0, 4'd5); repeat (6) tick();
        chk("ext_count", 32'(cdb_res.size()), 32'd4);
        chk("lb_result",  qa(cdb_res, 0), 32'hFFFF_FF80);
        chk("lbu_result", qa(cdb_res, 1), 32'h0000_0080);
        chk("lh_result",  qa(cdb_res, 2), 32'hFFFF_8000);
        chk("lhu_result", qa(cdb_res, 3), 32'h0000_8000);
        chk("lh_rob",     qa(cdb_rob, 2), 32'd4);

        // Byte store latency.
        clear_logs();
        issue(`SB, 32'h50, 32'h0000_00EE, 32'h0, 4'd6);
        repeat (5) tick();
        chk("sb_latency", qa(cdb_cyc, 0), 32'(t_issue + 3));
        chk("sb_result", qa(cdb_res, 0), 32'd0);
        chk("sb_is_write", qa(g_wr, 0), 32'd1);
        chk("sb_mem", 32'(mem[10'h050]), 32'h0000_00EE);

        // Misaligned half store, grant every other cycle.
        gnt_alt = 1'b1; hold_bad = 0; hold_cnt = 0;
        clear_logs();
        issue(`SH, 32'h200, 32'hAABB_CCDD, 32'hFFFF_FFFF, 4'd7);
        repeat (12) tick();
        gnt_alt = 1'b0;
        chk("sh_grants", 32'(g_addr.size()), 32'd2);
        chk("sh_addr0", qa(g_addr, 0), 32'h1FF);
        chk("sh_dat0",  qa(g_dat, 0), 32'hDD);
        chk("sh_addr1", qa(g_addr, 1), 32'h200);
        chk("sh_dat1",  qa(g_dat, 1), 32'hCC);
        chk("sh_cdb_count", 32'(cdb_res.size()), 32'd1);
        chk("sh_result", qa(cdb_res, 0), 32'd0);
        chk("sh_rob", qa(cdb_rob, 0), 32'd7);
        chk("sh_hold_seen", 32'(hold_cnt > 0), 32'd1);
        chk("sh_hold_ok", 32'(hold_bad), 32'd0);

        // Flush a load after two grants.
        clear_logs();
        issue(`LW, 32'h104, 32'h0, 32'h0, 4'd8);
        tick(); tick();
        refresh_rob_cdb_in = 1'b1; tick(); refresh_rob_cdb_in = 1'b0;
        chk("ld_flush_idle", 32'(idle_lsb_out), 32'd1);
        chk("ld_flush_req", 32'(mem_req_out), 32'd0);
        repeat (6) tick();
        chk("ld_flush_no_cdb", 32'(cdb_res.size()), 32'd0);

        // Flush a store after one grant: it still completes, silently.
        clear_logs();
        issue(`SW, 32'h300, 32'h1122_3344, 32'h0, 4'd9);
        tick();
        refresh_rob_cdb_in = 1'b1; tick(); refresh_rob_cdb_in = 1'b0;
        repeat (8) tick();
        chk("st_flush_grants", 32'(g_addr.size()), 32'd4);
        chk("st_flush_dat0", qa(g_dat, 0), 32'h44);
        chk("st_flush_addr3", qa(g_addr, 3), 32'h303);
        chk("st_flush_dat3", qa(g_dat, 3), 32'h11);
        chk("st_flush_no_cdb", 32'(cdb_res.size()), 32'd0);
        chk("st_flush_idle", 32'(idle_lsb_out), 32'd1);

        // Refresh in the issue cycle blocks acceptance.
        clear_logs();
        refresh_rob_cdb_in = 1'b1;
        issue(`LB, 32'h10, 32'h0, 32'h0, 4'd2);
        refresh_rob_cdb_in = 1'b0;
        chk("refresh_issue_idle", 32'(idle_lsb_out), 32'd1);
        chk("refresh_issue_req", 32'(mem_req_out), 32'd0);
        repeat (4) tick();
        chk("refresh_issue_no_cdb", 32'(cdb_res.size()), 32'd0);

        // Back-to-back byte loads.
        mem[10'h040] = 8'h5A; mem[10'h041] = 8'hA5;
        clear_logs();
        issue(`LB, 32'h40, 32'h0, 32'h0, 4'd10);
        t0 = t_issue;
        tick(); tick();
        chk("b2b_done", 32'(rdy_cdb_out), 32'd1);
        tick();
        chk("b2b_idle", 32'(idle_lsb_out), 32'd1);
        issue(`LB, 32'h41, 32'h0, 32'h0, 4'd11);
        chk("b2b_accepted", 32'(idle_lsb_out), 32'd0);
        repeat (5) tick();
        chk("b2b_count", 32'(cdb_res.size()), 32'd2);
        chk("b2b_res0", qa(cdb_res, 0), 32'h0000_005A);
        chk("b2b_rob0", qa(cdb_rob, 0), 32'd10);
        chk("b2b_res1", qa(cdb_res, 1), 32'hFFFF_FFA5);
        chk("b2b_rob1", qa(cdb_rob, 1), 32'd11);
        chk("b2b_cyc1", qa(cdb_cyc, 1), 32'(t0 + 7));

        // Reset mid-store.
        issue(`SW, 32'h300, 32'hCAFE_F00D, 32'h0, 4'd12);
        tick(); tick();
        rst_n_in = 1'b0; tick();
        chk_reset_outputs("midrst");
`ifdef LSC_PERF_CNT_EN
        chk("midrst_st_cnt", st_cnt_out, 32'd0);
`endif
        rst_n_in = 1'b1; tick();

        // Counter scenario: word load plus an I/O byte store.
        clear_logs();
        issue(`LW, 32'h100, 32'h0, 32'd4, 4'd13);
        repeat (8) tick();
        issue(`SB, 32'h3_0000, 32'h77, 32'h0, 4'd14);
        repeat (5) tick();
        chk("cnt_cdb_count", 32'(cdb_res.size()), 32'd2);
        chk("cnt_io_rob", qa(cdb_rob, 1), 32'd14);
`ifdef LSC_PERF_CNT_EN
        chk("ld_cnt", ld_cnt_out, 32'd1);
        chk("st_cnt", st_cnt_out, 32'd1);
        chk("io_cnt", io_cnt_out, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
